// File: rtl/dm_wb_cache.sv
// Direct-mapped, write-back, write-allocate cache between the core memory port and 256-bit line memory.
// Hits respond combinationally in IDLE; misses write back a dirty victim, then fill, then replay as a hit.
module dm_wb_cache #(
  parameter int NUM_SETS = 8,
  parameter int IDX_BITS = $clog2(NUM_SETS)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [3:0]   mem_byte_enable,
  input  logic [31:0]  mem_address,
  input  logic [31:0]  mem_wdata,
  output logic         mem_resp,
  output logic [31:0]  mem_rdata,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [31:0]  pmem_address,
  output logic [255:0] pmem_wdata,
  input  logic [255:0] pmem_rdata,
  input  logic         pmem_resp
);

  localparam int TAG_BITS = 27 - IDX_BITS;

  typedef enum logic [1:0] {IDLE, WRITEBACK, FILL} state_t;

  state_t               state;
  logic [NUM_SETS-1:0]  valid;
  logic [NUM_SETS-1:0]  dirty;
  logic [TAG_BITS-1:0]  tag_arr  [NUM_SETS];
  logic [255:0]         line_arr [NUM_SETS];

  logic [TAG_BITS-1:0]  tag;
  logic [IDX_BITS-1:0]  index;
  logic [2:0]           wsel;
  logic [7:0]           bit_off;
  logic                 req;
  logic                 hit;
  logic                 wr_hit;
  logic [31:0]          cur_word;
  logic [31:0]          merged_word;
  logic                 unused_addr;

  assign tag         = mem_address[31:5+IDX_BITS];
  assign index       = mem_address[4+IDX_BITS:5];
  assign wsel        = mem_address[4:2];
  assign bit_off     = {wsel, 5'd0};
  assign unused_addr = ^mem_address[1:0];

  assign req      = mem_read | mem_write;
  assign hit      = req & valid[index] & (tag_arr[index] == tag);
  assign cur_word = line_arr[index][bit_off +: 32];

  assign mem_resp  = ~rst & (state == IDLE) & hit;
  assign mem_rdata = cur_word;
  // A simultaneous read+write strobe is serviced as a write.
  assign wr_hit    = mem_resp & mem_write;

  always_comb begin
    merged_word = cur_word;
    for (int b = 0; b < 4; b++) begin
      if (mem_byte_enable[b]) merged_word[8*b +: 8] = mem_wdata[8*b +: 8];
    end
  end

  // Writeback targets the victim's tag; fill targets the requested tag.
  assign pmem_address = (state == WRITEBACK) ? {tag_arr[index], index, 5'd0}
                                             : {tag, index, 5'd0};
  assign pmem_wdata   = line_arr[index];

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      valid      <= '0;
      dirty      <= '0;
      pmem_read  <= 1'b0;
      pmem_write <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req && !hit) begin
            if (valid[index] && dirty[index]) begin
              state      <= WRITEBACK;
              pmem_write <= 1'b1;
            end else begin
              state     <= FILL;
              pmem_read <= 1'b1;
            end
          end else if (wr_hit) begin
            dirty[index] <= 1'b1;
          end
        end
        WRITEBACK: begin
          if (pmem_resp) begin
            dirty[index] <= 1'b0;
            state        <= FILL;
            pmem_write   <= 1'b0;
            pmem_read    <= 1'b1;
          end
        end
        FILL: begin
          if (pmem_resp) begin
            valid[index] <= 1'b1;
            dirty[index] <= 1'b0;
            state        <= IDLE;
            pmem_read    <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          pmem_read  <= 1'b0;
          pmem_write <= 1'b0;
        end
      endcase
    end
  end

  // Line and tag storage carry no reset; valid bits qualify them.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (wr_hit) begin
        line_arr[index][bit_off +: 32] <= merged_word;
      end else if (state == FILL && pmem_resp) begin
        line_arr[index] <= pmem_rdata;
        tag_arr[index]  <= tag;
      end
    end
  end

endmodule
